demux_1to2_buf: RTL and testbench

- Registered 1-to-2 demultiplexer with a valid/ready handshake on every port.
- Takes one producer stream and steers each word to one of two consumers, using a one-entry holding register per output.
- Sits between the EX/MEM result path and two independent sinks, e.g. the register-file write port and the HI/LO or store buffer.
- Provides per-port delivered-word counters for debug and performance.

---
 rtl/demux_1to2_buf.sv | 63 ++++++
 tb/tb_demux_1to2_buf.sv | 107 ++++++++++
 2 files changed

// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: registered 1-to-2 demux with one-entry holding slots and per-port delivered-word counters
module demux_1to2_buf #(
  parameter int size  = 32,
  parameter int cnt_w = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [cnt_w-1:0] count0_o,
  output logic [cnt_w-1:0] count1_o
);
  logic [size-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic [cnt_w-1:0] count0_q, count0_d, count1_q, count1_d;
  logic             acc, ld0, ld1, dr0, dr1;
  // Ready looks only at the selected slot, so a stalled other port never blocks.
  always_comb begin
    ready_o  = rst_i & (select_i ? (~valid1_q | ready1_i) : (~valid0_q | ready0_i));
    acc      = valid_i & ready_o;
    ld0      = acc & ~select_i;
    ld1      = acc & select_i;
    dr0      = valid0_q & ready0_i;
    dr1      = valid1_q & ready1_i;
    valid0_d = ld0 | (valid0_q & ~dr0);
    valid1_d = ld1 | (valid1_q & ~dr1);
    data0_d  = ld0 ? data_i : data0_q;
    data1_d  = ld1 ? data_i : data1_q;
    count0_d = count0_q + cnt_w'(dr0);
    count1_d = count1_q + cnt_w'(dr1);
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
    end
  end
  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign count0_o = count0_q;
  assign count1_o = count1_q;
endmodule

// File: tb/tb_demux_1to2_buf.sv
// tb_demux_1to2_buf: random + directed traffic checked by a per-port queue scoreboard
module tb_demux_1to2_buf;
  logic        clk_i = 0, rst_i = 0;
  logic [31:0] data_i = 0, data0_o, data1_o;
  logic        select_i = 0, valid_i = 0, ready_o;
  logic        valid0_o, ready0_i = 0, valid1_o, ready1_i = 0;
  logic [7:0]  count0_o, count1_o;
  logic [31:0] q0[$], q1[$];
  logic [7:0]  m0 = 0, m1 = 0;
  int          checks = 0, errs = 0;

  demux_1to2_buf #(.size(32), .cnt_w(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(ready0_i),
    .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(ready1_i),
    .count0_o(count0_o), .count1_o(count1_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; an accepted word becomes the expected next word of its port.
  task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic r0, input logic r1);
    @(negedge clk_i);
    valid_i = v; select_i = s; data_i = d; ready0_i = r0; ready1_i = r1;
    #2;
    if (valid_i && ready_o) begin
      if (s) q1.push_back(d);
      else q0.push_back(d);
    end
  endtask

  task automatic pulse_reset();
    #1 rst_i = 0;
    valid_i = 1;
    #1;
    chk("rst_valid0", valid0_o, 0);
    chk("rst_valid1", valid1_o, 0);
    chk("rst_count0", count0_o, 0);
    chk("rst_count1", count1_o, 0);
    chk("rst_ready", ready_o, 0);
    q0.delete(); q1.delete(); m0 = 0; m1 = 0;
    @(negedge clk_i);
    valid_i = 0;
    rst_i = 1;
  endtask

  // Monitor: slot contents must equal the model queue head; drains pop and advance the count.
  always begin
    @(negedge clk_i);
    #1;
    if (rst_i) begin
      chk("valid0", valid0_o, q0.size() != 0);
      chk("valid1", valid1_o, q1.size() != 0);
      if (q0.size() != 0) chk("data0", data0_o, q0[0]);
      if (q1.size() != 0) chk("data1", data1_o, q1[0]);
      chk("count0", count0_o, m0);
      chk("count1", count1_o, m1);
      chk("ready", ready_o, select_i ? (q1.size() == 0 || ready1_i) : (q0.size() == 0 || ready0_i));
      if (q0.size() != 0 && ready0_i) begin void'(q0.pop_front()); m0 = m0 + 1; end
      if (q1.size() != 0 && ready1_i) begin void'(q1.pop_front()); m1 = m1 + 1; end
    end
  end

  initial begin
    #3;
    chk("por_valid0", valid0_o, 0);
    chk("por_ready", ready_o, 0);
    @(negedge clk_i);
    rst_i = 1;
    cyc(0, 0, 0, 0, 1);
    pulse_reset();
    cyc(1, 1, 32'h1234_5678, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 32'hA, 0, 0);
    cyc(1, 0, 32'hB, 0, 0);
    cyc(1, 0, 32'hB, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 32'hA, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 1, i, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 32'h55, 0, 0);
    cyc(1, 1, 32'h66, 0, 1);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) cyc(1, 0, $urandom, 1, 0);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    cyc(1, 0, 32'hC0, 0, 0);
    cyc(1, 1, 32'hC1, 0, 0);
    pulse_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 50; i++) cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
